// File: rtl/array_key_scan.sv
// 4x4 active-low matrix keypad scanner: column debounce, row scan, one strobe per press.
// Define ARRAY_KEY_GHOST_REJECT_EN to discard scans that see more than one closed contact.
module array_key_scan #(
  parameter int TIME_20ms = 1_000_000,
  parameter int TIME_1ms  = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_num,
  output logic       key_vld
);

  localparam int DW = (TIME_20ms > 1) ? $clog2(TIME_20ms + 1) : 1;
  localparam int RW = (TIME_1ms > 1) ? $clog2(TIME_1ms + 1) : 1;

  typedef enum logic [2:0] {IDLE, DEBOUNCE, SCAN, REPORT, WAIT_REL} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    col_r;
  logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
  logic [RW-1:0] row_cnt_reg, row_cnt_next;
  logic [1:0]    row_idx_reg, row_idx_next;
  logic          hit_reg, hit_next;
  logic [1:0]    hit_row_reg, hit_row_next;
  logic [1:0]    hit_col_reg, hit_col_next;
  logic [3:0]    key_row_next, key_num_next;
  logic          key_vld_next;

  logic       col_idle, row_last, samp_en, samp_hit;
  logic [1:0] samp_col, fin_row, fin_col;
  logic       fin_hit, scan_bad;

  assign col_idle = (col_r == 4'hf);
  assign row_last = (row_cnt_reg == RW'(TIME_1ms - 1));
  assign samp_en  = (state_reg == SCAN) && row_last;
  assign samp_hit = (key_col != 4'hf);

  // Lowest-numbered closed column wins within a row.
  always_comb begin
    samp_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!key_col[i]) samp_col = 2'(i);
    end
  end

  // Result of the scan including the sample taken in the current cycle.
  assign fin_hit = hit_reg | (samp_en & samp_hit);
  assign fin_row = hit_reg ? hit_row_reg : row_idx_reg;
  assign fin_col = hit_reg ? hit_col_reg : samp_col;

`ifdef ARRAY_KEY_GHOST_REJECT_EN
  logic multi_reg, multi_next, samp_multi;

  // Two or more zero bits in one column sample.
  assign samp_multi = ((~key_col & (~key_col - 4'd1)) != 4'd0);
  assign multi_next = (state_reg != SCAN) ? 1'b0 :
                      (multi_reg | (samp_en & samp_hit & (samp_multi | hit_reg)));
  assign scan_bad   = multi_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) multi_reg <= 1'b0;
    else        multi_reg <= multi_next;
  end
`else
  assign scan_bad = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      col_r       <= 4'hf;
      deb_cnt_reg <= '0;
      row_cnt_reg <= '0;
      row_idx_reg <= 2'd0;
      hit_reg     <= 1'b0;
      hit_row_reg <= 2'd0;
      hit_col_reg <= 2'd0;
      key_row     <= 4'b0000;
      key_num     <= 4'h0;
      key_vld     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_r       <= key_col;
      deb_cnt_reg <= deb_cnt_next;
      row_cnt_reg <= row_cnt_next;
      row_idx_reg <= row_idx_next;
      hit_reg     <= hit_next;
      hit_row_reg <= hit_row_next;
      hit_col_reg <= hit_col_next;
      key_row     <= key_row_next;
      key_num     <= key_num_next;
      key_vld     <= key_vld_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (!col_idle) state_next = DEBOUNCE;
      DEBOUNCE: begin
        if (col_idle)                                 state_next = IDLE;
        else if (deb_cnt_reg == DW'(TIME_20ms - 1))   state_next = SCAN;
      end
      SCAN:     begin
        if (row_last && row_idx_reg == 2'd3)
          state_next = (fin_hit && !scan_bad) ? REPORT : IDLE;
      end
      REPORT:   state_next = WAIT_REL;
      WAIT_REL: if (col_idle) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Counters and hit capture; everything clears outside its own state.
  always_comb begin
    deb_cnt_next = '0;
    row_cnt_next = '0;
    row_idx_next = 2'd0;
    hit_next     = 1'b0;
    hit_row_next = hit_row_reg;
    hit_col_next = hit_col_reg;
    if (state_reg == DEBOUNCE) deb_cnt_next = deb_cnt_reg + 1'b1;
    if (state_next == SCAN && state_reg == SCAN) begin
      row_cnt_next = row_last ? '0 : row_cnt_reg + 1'b1;
      row_idx_next = row_last ? row_idx_reg + 2'd1 : row_idx_reg;
      hit_next     = fin_hit;
      hit_row_next = fin_row;
      hit_col_next = fin_col;
    end
  end

  // Output logic, evaluated on the upcoming state so the outputs can be registered.
  always_comb begin
    key_row_next = 4'b0000;
    key_vld_next = 1'b0;
    key_num_next = key_num;
    case (state_next)
      SCAN:    key_row_next = ~(4'b0001 << row_idx_next);
      REPORT: begin
        key_vld_next = 1'b1;
        key_num_next = {fin_row, fin_col};
      end
      default: key_row_next = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_array_key_scan.sv
// Bench for array_key_scan: physical keypad model plus a press-level expectation model.
// Honours ARRAY_KEY_GHOST_REJECT_EN for the expected acceptance rule.
module tb_array_key_scan;

  localparam int T20 = 5;
  localparam int T1  = 1;
  localparam int LAT = 2 + T20 + 4 * T1;  // clock edges from press to strobe

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_col, key_row, key_num;
  logic       key_vld;
  logic [15:0] pressed = 16'h0;  // bit r*4+c = key at row r, column c closed
  logic [3:0]  last_code = 4'h0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // A column reads low when a closed key connects it to a driven-low row.
  always_comb begin
    key_col = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
  end

  array_key_scan #(.TIME_20ms(T20), .TIME_1ms(T1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_col (key_col),
    .key_row (key_row),
    .key_num (key_num),
    .key_vld (key_vld)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit accepted(input logic [15:0] m);
`ifdef ARRAY_KEY_GHOST_REJECT_EN
    return $countones(m) == 1;
`else
    return m != 16'h0;
`endif
  endfunction

  // Key code equals the row-major key index, so the winner is the lowest set bit.
  function automatic logic [3:0] lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++)
      if (m[i]) return 4'(i);
    return 4'h0;
  endfunction

  // Press mask m for `hold` cycles, then release and idle for `gap` cycles.
  task automatic run_press(input logic [15:0] m, input int hold, input int gap, input string tag);
    bit debounced;
    bit strobe;
    logic [3:0] row_exp;
    debounced = (m != 16'h0) && (hold >= LAT + 1);
    strobe    = debounced && accepted(m);
    @(posedge clk); #1;
    pressed = m;
    for (int i = 1; i <= hold + gap; i++) begin
      @(posedge clk); #1;
      if (strobe && i == LAT) last_code = lowest(m);
      row_exp = 4'b0000;
      if (debounced && i >= LAT - 4 && i < LAT) row_exp = 4'b1111 ^ (4'b0001 << (i - (LAT - 4)));
      check({tag, "_vld"}, {3'b000, key_vld}, {3'b000, (strobe && i == LAT)});
      check({tag, "_num"}, key_num, last_code);
      check({tag, "_row"}, key_row, row_exp);
      if (i == hold) pressed = 16'h0;
    end
    $display("press %s mask=%h hold=%0d strobe=%0d code=%h", tag, m, hold, strobe, last_code);
  endtask

  initial begin
    logic [15:0] m;
    int hold;
    #2;
    check("rst_row", key_row, 4'b0000);
    check("rst_num", key_num, 4'h0);
    check("rst_vld", {3'b000, key_vld}, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Column forced regardless of rows == the same column closed in every row.
    run_press(16'h1111, 15, 4, "col1110");
    run_press(16'h8888, 15, 4, "col0111");
    run_press(16'h4444, 15, 4, "col1011");
    run_press(16'h2222, 3, 4, "short1101");
    run_press(16'h0200, 20, 4, "row2col1");
    run_press(16'h3333, 15, 4, "col1100");

    // Reset in the middle of a scan.
    pressed = 16'h0020;
    repeat (LAT - 3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_row", key_row, 4'b0000);
    check("midrst_num", key_num, 4'h0);
    check("midrst_vld", {3'b000, key_vld}, 4'h0);
    pressed = 16'h0;
    last_code = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_press(16'h0000, 0, 20, "postrst");

    // Randomized presses: one or two keys, clearly short or clearly long.
    for (int k = 0; k < 14; k++) begin
      m = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) m = m | (16'h1 << $urandom_range(0, 15));
      hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(LAT + 1, LAT + 14));
      run_press(m, hold, 4, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
